// File: rtl/arm_exec_ctrl_core_pkg.sv
// ----------------------------------------------------------------------------
// arm_exec_ctrl_core_pkg
// Shared constants for the ARMv4-subset decode/execute slice: ALU opcodes
// (ARM data-processing numbering), condition codes, addressing-mode encodings
// and NZCV bit positions, plus the condition-code evaluation helper.
// No ports.
// ----------------------------------------------------------------------------
package arm_exec_ctrl_core_pkg;

    // ALU opcodes, identical to the data-processing opcode field [24:21]
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_EOR = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_RSB = 4'h3;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_ADC = 4'h5;
    localparam logic [3:0] ALU_SBC = 4'h6;
    localparam logic [3:0] ALU_RSC = 4'h7;
    localparam logic [3:0] ALU_TST = 4'h8;
    localparam logic [3:0] ALU_TEQ = 4'h9;
    localparam logic [3:0] ALU_CMP = 4'hA;
    localparam logic [3:0] ALU_CMN = 4'hB;
    localparam logic [3:0] ALU_ORR = 4'hC;
    localparam logic [3:0] ALU_MOV = 4'hD;
    localparam logic [3:0] ALU_BIC = 4'hE;
    localparam logic [3:0] ALU_MVN = 4'hF;

    // Condition codes, instruction field [31:28]
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Addressing modes
    localparam logic [1:0] AM_IMM_ROT   = 2'b00;  // rotated imm8
    localparam logic [1:0] AM_IMM_SHIFT = 2'b01;  // register shifted by immediate
    localparam logic [1:0] AM_REG_SHIFT = 2'b10;  // register shifted by register
    localparam logic [1:0] AM_IMM12     = 2'b11;  // load/store 12-bit offset

    // Bit positions inside {N,Z,C,V}
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[NZCV_N];
        z = nzcv[NZCV_Z];
        c = nzcv[NZCV_C];
        v = nzcv[NZCV_V];
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = !z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = !c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = !n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = !v;
            COND_HI: cond_eval = c && !z;
            COND_LS: cond_eval = !c || z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = !z && (n == v);
            COND_LE: cond_eval = z || (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;  // COND_NV
        endcase
    endfunction

endpackage

// File: rtl/arm_exec_ctrl_core_alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Combinational 32-bit ARM ALU with NZCV flag generation.
// Ports:
//   a_i, b_i   in  DATA_W  operands (A = Rn, B = shifter output)
//   op_i       in  4       ALU opcode
//   c_in_i     in  1       current PSR C (carry-in and logic-op C passthrough)
//   v_in_i     in  1       current PSR V (logic-op V passthrough)
//   result_o   out DATA_W  result
//   n_o..v_o   out 1       live flags
// ----------------------------------------------------------------------------
module alu_core
    import arm_exec_ctrl_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        op_i,
    input  logic              c_in_i,
    input  logic              v_in_i,
    output logic [DATA_W-1:0] result_o,
    output logic              n_o,
    output logic              z_o,
    output logic              c_o,
    output logic              v_o
);

    logic [DATA_W-1:0] x_op;
    logic [DATA_W-1:0] y_op;
    logic              cin;
    logic              arith;
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W:0]   sum;

    // Every arithmetic op is folded into x + y + cin; subtraction uses
    // x + ~y + 1 (or + C for the with-carry forms), so the sum's top bit is
    // directly ARM's "no borrow" carry.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        x_op      = a_i;
        y_op      = b_i;
        cin       = 1'b0;
        arith     = 1'b0;
        logic_res = '0;
        case (op_i)
            ALU_AND, ALU_TST: logic_res = a_i & b_i;
            ALU_EOR, ALU_TEQ: logic_res = a_i ^ b_i;
            ALU_SUB, ALU_CMP: begin arith = 1'b1; y_op = ~b_i; cin = 1'b1;   end
            ALU_RSB:          begin arith = 1'b1; x_op = b_i; y_op = ~a_i; cin = 1'b1; end
            ALU_ADD, ALU_CMN: begin arith = 1'b1; end
            ALU_ADC:          begin arith = 1'b1; cin = c_in_i; end
            ALU_SBC:          begin arith = 1'b1; y_op = ~b_i; cin = c_in_i; end
            ALU_RSC:          begin arith = 1'b1; x_op = b_i; y_op = ~a_i; cin = c_in_i; end
            ALU_ORR:          logic_res = a_i | b_i;
            ALU_MOV:          logic_res = b_i;
            ALU_BIC:          logic_res = a_i & ~b_i;
            default:          logic_res = ~b_i;  // ALU_MVN
        endcase
    end

    assign sum      = {1'b0, x_op} + {1'b0, y_op} + {{DATA_W{1'b0}}, cin};
    assign result_o = arith ? sum[DATA_W-1:0] : logic_res;
    assign n_o      = result_o[DATA_W-1];
    assign z_o      = (result_o == '0);
    assign c_o      = arith ? sum[DATA_W] : c_in_i;
    // Overflow: both addends share a sign that the result does not.
    assign v_o      = arith ? ((x_op[DATA_W-1] == y_op[DATA_W-1]) &&
                               (sum[DATA_W-1] != x_op[DATA_W-1]))
                            : v_in_i;

endmodule

// File: rtl/arm_exec_ctrl_core.sv
// ----------------------------------------------------------------------------
// arm_exec_ctrl_core
// ARMv4-subset ID/EX slice: combinational control unit, ALU with registered
// NZCV status register, and B/BL condition resolution.
// Ports:
//   clk, reset (async, active-low)
//   instruction, ctrl_nop -> id_* decoded control outputs
//   ex_a, ex_b, ex_alu_op, ex_store_cc -> alu_result, alu_n/z/c/v, psr_nzcv
//   branched, ex_bl_out  branch-taken / link-write requests
// Configuration macro: COND_FWD_EN -- when defined, the condition handler
//   uses the live ALU flags in a cycle where ex_store_cc=1; otherwise it
//   always uses psr_nzcv.
// ----------------------------------------------------------------------------
module arm_exec_ctrl_core
    import arm_exec_ctrl_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              ctrl_nop,
    output logic [3:0]        id_alu_op,
    output logic [1:0]        id_am,
    output logic              id_load,
    output logic              id_mem_write,
    output logic              id_mem_size,
    output logic              id_mem_e,
    output logic              id_rf_e,
    output logic              id_store_cc,
    output logic              id_b,
    output logic              id_bl,
    input  logic [DATA_W-1:0] ex_a,
    input  logic [DATA_W-1:0] ex_b,
    input  logic [3:0]        ex_alu_op,
    input  logic              ex_store_cc,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_n,
    output logic              alu_z,
    output logic              alu_c,
    output logic              alu_v,
    output logic [3:0]        psr_nzcv,
    output logic              ex_bl_out,
    output logic              branched
);

    logic [3:0] psr_q;
    logic [3:0] psr_d;
    logic [3:0] cond_flags;
    logic       cond_true;

    // ---------------- Decode ----------------
    always_comb begin
        id_alu_op    = 4'h0;
        id_am        = 2'b00;
        id_load      = 1'b0;
        id_mem_write = 1'b0;
        id_mem_size  = 1'b0;
        id_mem_e     = 1'b0;
        id_rf_e      = 1'b0;
        id_store_cc  = 1'b0;
        id_b         = 1'b0;
        id_bl        = 1'b0;
        if (!ctrl_nop && (instruction != 32'h0)) begin
            if (instruction[27:26] == 2'b00) begin
                id_alu_op   = instruction[24:21];
                id_store_cc = instruction[20];
                // TST/TEQ/CMP/CMN only set flags
                id_rf_e     = (instruction[24:23] != 2'b10);
                id_am       = instruction[25] ? AM_IMM_ROT
                            : instruction[4]  ? AM_REG_SHIFT : AM_IMM_SHIFT;
            end else if (instruction[27:26] == 2'b01) begin
                id_mem_e     = 1'b1;
                id_load      = instruction[20];
                id_mem_write = ~instruction[20];
                id_mem_size  = instruction[22];
                id_rf_e      = instruction[20];
                id_alu_op    = instruction[23] ? ALU_ADD : ALU_SUB;
                id_am        = instruction[25] ? AM_IMM_SHIFT : AM_IMM12;
            end else if (instruction[27:25] == 3'b101) begin
                id_b  = ~instruction[24];
                id_bl = instruction[24];
            end
        end
    end

    // ---------------- Execute ----------------
    alu_core #(.DATA_W(DATA_W)) u_alu (
        .a_i      (ex_a),
        .b_i      (ex_b),
        .op_i     (ex_alu_op),
        .c_in_i   (psr_q[NZCV_C]),
        .v_in_i   (psr_q[NZCV_V]),
        .result_o (alu_result),
        .n_o      (alu_n),
        .z_o      (alu_z),
        .c_o      (alu_c),
        .v_o      (alu_v)
    );

    assign psr_d = ex_store_cc ? {alu_n, alu_z, alu_c, alu_v} : psr_q;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset) psr_q <= 4'b0000;
        else        psr_q <= psr_d;
    end

    assign psr_nzcv = psr_q;

    // ---------------- Condition handler ----------------
`ifdef COND_FWD_EN
    // Forward the flags being written this cycle so CMP-then-B needs no stall.
    assign cond_flags = ex_store_cc ? {alu_n, alu_z, alu_c, alu_v} : psr_q;
`else
    assign cond_flags = psr_q;
`endif

    assign cond_true = cond_eval(instruction[31:28], cond_flags);
    assign branched  = reset & (id_b | id_bl) & cond_true;
    assign ex_bl_out = reset & id_bl & cond_true;

endmodule

// File: tb/tb_arm_exec_ctrl_core.sv
`timescale 1ns/1ps
module tb_arm_exec_ctrl_core;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        ctrl_nop;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_am;
    logic        id_load, id_mem_write, id_mem_size, id_mem_e, id_rf_e, id_store_cc, id_b, id_bl;
    logic [31:0] ex_a, ex_b;
    logic [3:0]  ex_alu_op;
    logic        ex_store_cc;
    logic [31:0] alu_result;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic [3:0]  psr_nzcv;
    logic        ex_bl_out, branched;

    int n_checks = 0;
    int n_fail   = 0;

    wire [13:0] dec_bus = {id_alu_op, id_am, id_load, id_mem_write, id_mem_size,
                           id_mem_e, id_rf_e, id_store_cc, id_b, id_bl};
    wire [3:0]  live_nzcv = {alu_n, alu_z, alu_c, alu_v};

    arm_exec_ctrl_core #(.DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .ctrl_nop     (ctrl_nop),
        .id_alu_op    (id_alu_op),
        .id_am        (id_am),
        .id_load      (id_load),
        .id_mem_write (id_mem_write),
        .id_mem_size  (id_mem_size),
        .id_mem_e     (id_mem_e),
        .id_rf_e      (id_rf_e),
        .id_store_cc  (id_store_cc),
        .id_b         (id_b),
        .id_bl        (id_bl),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_alu_op    (ex_alu_op),
        .ex_store_cc  (ex_store_cc),
        .alu_result   (alu_result),
        .alu_n        (alu_n),
        .alu_z        (alu_z),
        .alu_c        (alu_c),
        .alu_v        (alu_v),
        .psr_nzcv     (psr_nzcv),
        .ex_bl_out    (ex_bl_out),
        .branched     (branched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_in(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic store);
        ex_a        = a;
        ex_b        = b;
        ex_alu_op   = op;
        ex_store_cc = store;
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ins);
        instruction = ins;
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        instruction = 32'h0;
        ctrl_nop    = 1'b0;
        ex_a        = 32'h0;
        ex_b        = 32'h0;
        ex_alu_op   = 4'h0;
        ex_store_cc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("psr_por", {28'h0, psr_nzcv}, 32'h0);
        reset = 1'b1;
        tick();

        // ---- Data-processing decode ----
        set_instr(32'hE0810002);  // ADD r0,r1,r2
        check("add_alu_op",   {28'h0, id_alu_op}, 32'h4);
        check("add_rf_e",     {31'h0, id_rf_e}, 32'h1);
        check("add_am",       {30'h0, id_am}, 32'h1);
        check("add_store_cc", {31'h0, id_store_cc}, 32'h0);
        check("add_mem_e",    {31'h0, id_mem_e}, 32'h0);
        set_instr(32'h0);
        check("zero_instr",   {18'h0, dec_bus}, 32'h0);
        set_instr(32'hE1510002);  // CMP r1,r2 : flags only
        check("cmp_alu_op",   {28'h0, id_alu_op}, 32'hA);
        check("cmp_rf_e",     {31'h0, id_rf_e}, 32'h0);
        check("cmp_store_cc", {31'h0, id_store_cc}, 32'h1);
        set_instr(32'hE3A00001);  // MOV r0,#1
        check("mov_imm_am",   {30'h0, id_am}, 32'h0);
        check("mov_alu_op",   {28'h0, id_alu_op}, 32'hD);
        set_instr(32'hE0810312);  // ADD r0,r1,r2,LSL r3
        check("rsr_am",       {30'h0, id_am}, 32'h2);
        set_instr(32'hEE000000);  // coprocessor space -> nothing
        check("undef_instr",  {18'h0, dec_bus}, 32'h0);

        // ---- Load/store decode ----
        set_instr(32'hE5D12004);  // LDRB r2,[r1,#4]
        check("ldrb_load",    {31'h0, id_load}, 32'h1);
        check("ldrb_size",    {31'h0, id_mem_size}, 32'h1);
        check("ldrb_mem_e",   {31'h0, id_mem_e}, 32'h1);
        check("ldrb_alu_op",  {28'h0, id_alu_op}, 32'h4);
        check("ldrb_rf_e",    {31'h0, id_rf_e}, 32'h1);
        check("ldrb_am",      {30'h0, id_am}, 32'h3);
        check("ldrb_mem_wr",  {31'h0, id_mem_write}, 32'h0);
        ctrl_nop = 1'b1;
        #1;
        check("nop_bubble",   {18'h0, dec_bus}, 32'h0);
        ctrl_nop = 1'b0;
        set_instr(32'hE7812003);  // STR r2,[r1,r3]
        check("str_mem_wr",   {31'h0, id_mem_write}, 32'h1);
        check("str_rf_e",     {31'h0, id_rf_e}, 32'h0);
        check("str_am",       {30'h0, id_am}, 32'h1);
        set_instr(32'hE5112004);  // LDR r2,[r1,#-4]
        check("ldr_down_op",  {28'h0, id_alu_op}, 32'h2);

        // ---- ALU / PSR ----
        alu_in(32'd5, 32'd5, 4'hA, 1'b1);  // CMP 5,5
        check("cmp_result", alu_result, 32'h0);
        check("cmp_flags",  {28'h0, live_nzcv}, 32'h6);
        tick();
        check("cmp_psr",    {28'h0, psr_nzcv}, 32'h6);
        alu_in(32'd1, 32'd1, 4'h5, 1'b0);  // ADC uses psr C=1
        check("adc_result", alu_result, 32'd3);
        alu_in(32'd5, 32'd3, 4'h6, 1'b0);  // SBC with C=1 -> plain subtract
        check("sbc_result", alu_result, 32'd2);
        alu_in(32'd9, 32'h0, 4'hD, 1'b0);  // MOV 0: C/V pass from psr
        check("mov_flags",  {28'h0, live_nzcv}, 32'h6);
        alu_in(32'h0, 32'h1, 4'h2, 1'b0);  // SUB 0-1: borrow -> C=0
        check("sub_borrow_res",   alu_result, 32'hFFFFFFFF);
        check("sub_borrow_flags", {28'h0, live_nzcv}, 32'h8);
        alu_in(32'd3, 32'd10, 4'h3, 1'b0); // RSB 10-3
        check("rsb_result", alu_result, 32'd7);
        alu_in(32'hF0F0F0F0, 32'hFF00FF00, 4'hE, 1'b0); // BIC
        check("bic_result", alu_result, 32'h00F000F0);

        // ---- Branch resolution (psr = Z,C) ----
        set_instr(32'h0A000004);  // BEQ
        check("beq_taken",   {31'h0, branched}, 32'h1);
        check("beq_no_link", {31'h0, ex_bl_out}, 32'h0);
        set_instr(32'h1A000004);  // BNE
        check("bne_not",     {31'h0, branched}, 32'h0);
        set_instr(32'h8A000004);  // BHI: C & !Z false
        check("bhi_not",     {31'h0, branched}, 32'h0);
        alu_in(32'd1, 32'd1, 4'h4, 1'b1);  // ADD 1+1 clears flags
        tick();
        ex_store_cc = 1'b0;
        #1;
        check("add_psr",     {28'h0, psr_nzcv}, 32'h0);
        set_instr(32'h0A000004);
        check("beq_z0",      {31'h0, branched}, 32'h0);
        set_instr(32'hEB000002);  // BL AL
        check("bl_taken",    {31'h0, branched}, 32'h1);
        check("bl_link",     {31'h0, ex_bl_out}, 32'h1);
        set_instr(32'hFB000002);  // BL never
        check("bl_never",    {31'h0, branched}, 32'h0);

        // ---- Signed overflow ----
        alu_in(32'h7FFFFFFF, 32'h1, 4'h4, 1'b1);
        check("ovf_result", alu_result, 32'h80000000);
        check("ovf_flags",  {28'h0, live_nzcv}, 32'h9);
        tick();
        ex_store_cc = 1'b0;
        #1;
        check("ovf_psr",    {28'h0, psr_nzcv}, 32'h9);
        set_instr(32'hAA000000);  // BGE: N==V
        check("bge_taken",  {31'h0, branched}, 32'h1);
        set_instr(32'hBA000000);  // BLT
        check("blt_not",    {31'h0, branched}, 32'h0);

        // ---- Asynchronous reset mid-run ----
        set_instr(32'hEB000002);
        check("pre_rst_br", {31'h0, branched}, 32'h1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_psr",    {28'h0, psr_nzcv}, 32'h0);
        check("rst_br",     {31'h0, branched}, 32'h0);
        check("rst_bl",     {31'h0, ex_bl_out}, 32'h0);
        alu_in(32'h7FFFFFFF, 32'h1, 4'h4, 1'b1);
        tick();
        check("rst_hold",   {28'h0, psr_nzcv}, 32'h0);
        ex_store_cc = 1'b0;
        reset = 1'b1;
        #1;
        check("post_rst_br", {31'h0, branched}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
